// File: rtl/srt_div_arbiter_if.sv
// srt_div_arbiter_if: requester handshakes plus the divider-core start/done bus of the arbiter.
interface srt_div_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_dividend;
    logic [31:0] req0_divisor;
    logic [31:0] req1_dividend;
    logic [31:0] req1_divisor;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_quotient;
    logic        resp_err;
    logic        busy;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_done;
    logic [31:0] div_quotient;
    modport slave (
        input  req_valid, req0_dividend, req0_divisor, req1_dividend, req1_divisor,
        input  resp_ready, div_done, div_quotient,
        output req_ready, resp_valid, resp_quotient, resp_err, busy,
        output div_start, div_dividend, div_divisor
    );
    modport master (
        output req_valid, req0_dividend, req0_divisor, req1_dividend, req1_divisor,
        output resp_ready, div_done, div_quotient,
        input  req_ready, resp_valid, resp_quotient, resp_err, busy,
        input  div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/srt_div_arbiter.sv
// srt_div_arbiter: round-robin sharing of one SRT divider core between two FP32 requesters,
// with a divide-by-zero bypass and a watchdog that aborts a stalled core.
module srt_div_arbiter #(
    parameter int TIMEOUT = 64
) (
    input logic clk,
    input logic rst,
    srt_div_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [31:0] QNAN = 32'h7fc0_0000;
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);
    state_t state;
    logic last, grant, pick, zero_divisor;
    logic [7:0] count;
    logic [31:0] dividend, divisor, bypass_quotient;
    // On a tie the requester that did not win last time gets the core.
    always_comb begin
        pick = &bus.req_valid ? ~last : bus.req_valid[1];
        dividend = pick ? bus.req1_dividend : bus.req0_dividend;
        divisor = pick ? bus.req1_divisor : bus.req0_divisor;
        zero_divisor = divisor[30:0] == 31'd0;
        bypass_quotient = (dividend[30:0] == 31'd0 || (&dividend[30:23] && |dividend[22:0])) ?
                          QNAN : {dividend[31] ^ divisor[31], 31'h7f80_0000};
        bus.req_ready = (!rst && state == IDLE) ? bus.req_valid & (pick ? 2'b10 : 2'b01) : 2'b00;
        bus.busy = state != IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last <= 1'b1;
            grant <= 1'b0;
            count <= '0;
            bus.resp_valid <= 2'b00;
            bus.resp_quotient <= '0;
            bus.resp_err <= 1'b0;
            bus.div_start <= 1'b0;
            bus.div_dividend <= '0;
            bus.div_divisor <= '0;
        end else begin
            case (state)
                IDLE: if (|bus.req_valid) begin
                    grant <= pick;
                    last <= pick;
                    bus.div_dividend <= dividend;
                    bus.div_divisor <= divisor;
                    bus.resp_quotient <= bypass_quotient;
                    bus.resp_err <= 1'b0;
                    bus.resp_valid <= zero_divisor ? (pick ? 2'b10 : 2'b01) : 2'b00;
                    bus.div_start <= !zero_divisor;
                    state <= zero_divisor ? RESP : ISSUE;
                end
                ISSUE: begin
                    bus.div_start <= 1'b0;
                    count <= '0;
                    state <= WAIT;
                end
                // A completion arriving on the last watchdog cycle still wins over the abort.
                WAIT: begin
                    count <= count + 8'd1;
                    if (bus.div_done || count == LAST_COUNT) begin
                        bus.resp_quotient <= bus.div_done ? bus.div_quotient : QNAN;
                        bus.resp_err <= !bus.div_done;
                        bus.resp_valid <= grant ? 2'b10 : 2'b01;
                        state <= RESP;
                    end
                end
                RESP: if (bus.resp_ready[grant]) begin
                    bus.resp_valid <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_srt_div_arbiter.sv
// tb_srt_div_arbiter: randomized bench with a divider-core responder and a transaction-level
// reference model of grant order, bypass results, latency and watchdog behaviour.
module tb_srt_div_arbiter;
    localparam int TO = 64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int mdl_last = 1;
    int core_n = 4;
    bit core_en = 1'b1;
    bit use_override = 1'b0;
    bit manual_done = 1'b0;
    logic [31:0] override_q = 32'h0;
    logic [31:0] core_q = 32'h0;
    int core_left = 0;
    srt_div_arbiter_if bus();
    srt_div_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
        return a ^ {b[15:0], b[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [31:0] bypass_ref(input logic [31:0] a, input logic [31:0] b);
        bit a_nan = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
        if (a[30:0] == 31'd0 || a_nan) return 32'h7fc0_0000;
        return (a[31] ^ b[31]) ? 32'hff80_0000 : 32'h7f80_0000;
    endfunction

    function automatic int exp_grant(input logic [1:0] mask);
        return (mask == 2'b11) ? 1 - mdl_last : int'(mask[1]);
    endfunction

    // Divider core: answers N cycles after the start pulse, or never when disabled.
    always @(posedge clk) begin
        if (bus.div_start) begin
            core_left <= core_en ? core_n : 0;
            core_q <= use_override ? override_q : core_fn(bus.div_dividend, bus.div_divisor);
        end else if (core_left > 0) core_left <= core_left - 1;
    end
    assign bus.div_done = (core_left == 1) || manual_done;
    assign bus.div_quotient = bus.div_done ? core_q : 32'hdead_beef;

    task automatic do_txn(input logic [1:0] mask, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1, input int rdelay,
                          output int g, output int lat, output logic [31:0] q, output logic err,
                          output logic [1:0] rv, output int start_cnt, output int start_k,
                          output bit stable_ok, output bit hold_ok, output bit ready_ok);
        logic [31:0] ca, cb;
        int w;
        g = -1; lat = -1; q = 32'hx; err = 1'bx; rv = 2'bxx;
        start_cnt = 0; start_k = -1; stable_ok = 1; hold_ok = 1; ready_ok = 1;
        @(negedge clk);
        bus.req_valid = mask;
        bus.req0_dividend = a0; bus.req0_divisor = b0;
        bus.req1_dividend = a1; bus.req1_divisor = b1;
        bus.resp_ready = 2'b00;
        #1;
        w = 0;
        while (bus.req_ready == 2'b00 && w < 50) begin @(negedge clk); #1; w++; end
        if (bus.req_ready == 2'b00) begin bus.req_valid = 2'b00; return; end
        g = bus.req_ready[1] ? 1 : 0;
        ca = g ? a1 : a0;
        cb = g ? b1 : b0;
        @(posedge clk);
        for (int k = 1; k <= TO + 10; k++) begin
            @(negedge clk);
            if (bus.div_start) begin start_cnt++; start_k = k; end
            if (bus.req_ready !== 2'b00 || bus.busy !== 1'b1) ready_ok = 0;
            if (start_cnt > 0 && (bus.div_dividend !== ca || bus.div_divisor !== cb)) stable_ok = 0;
            if (bus.resp_valid !== 2'b00) begin lat = k; break; end
            if (k == 1) begin
                bus.req_valid = 2'b11;
                bus.req0_dividend = $urandom; bus.req0_divisor = $urandom;
                bus.req1_dividend = $urandom; bus.req1_divisor = $urandom;
            end
            @(posedge clk);
        end
        if (lat < 0) begin bus.req_valid = 2'b00; return; end
        q = bus.resp_quotient; err = bus.resp_err; rv = bus.resp_valid;
        bus.req_valid = 2'b11;
        bus.resp_ready = g ? 2'b01 : 2'b10;
        for (int d = 0; d < rdelay; d++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.resp_valid !== rv || bus.resp_quotient !== q || bus.resp_err !== err ||
                bus.req_ready !== 2'b00 || bus.busy !== 1'b1) hold_ok = 0;
        end
        bus.resp_ready = g ? 2'b10 : 2'b01;
        @(posedge clk);
        @(negedge clk);
        if (bus.resp_valid !== 2'b00 || bus.busy !== 1'b0) hold_ok = 0;
        bus.req_valid = 2'b00;
        bus.resp_ready = 2'b00;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req_valid = 2'b11;
        repeat (2) @(negedge clk);
        tests++; if ({bus.req_ready, bus.resp_valid, bus.div_start, bus.busy, bus.resp_err} !== 7'd0)
            begin fails++; $display("FAIL reset_ctrl: got %b expected 0", {bus.req_ready, bus.resp_valid, bus.div_start, bus.busy, bus.resp_err}); end
        tests++; if (bus.resp_quotient !== 32'd0)
            begin fails++; $display("FAIL reset_quot: got %h expected 0", bus.resp_quotient); end
        tests++; if ({bus.div_dividend, bus.div_divisor} !== 64'd0)
            begin fails++; $display("FAIL reset_ops: got %h expected 0", {bus.div_dividend, bus.div_divisor}); end
        bus.req_valid = 2'b00;
        rst = 1'b0;
        mdl_last = 1;
    endtask

    task automatic test_basic;
        int g, lat, sc, sk; logic [31:0] q; logic err; logic [1:0] rv; bit st, ho, ro;
        core_en = 1; core_n = 10; use_override = 1; override_q = 32'h4000_0000;
        do_txn(2'b01, 32'h4080_0000, 32'h4000_0000, 32'h0, 32'h0, 0, g, lat, q, err, rv, sc, sk, st, ho, ro);
        mdl_last = 0;
        use_override = 0;
        tests++; if (g !== 0) begin fails++; $display("FAIL basic_grant: got %0d expected 0", g); end
        tests++; if (sk !== 1 || sc !== 1) begin fails++; $display("FAIL basic_start: got k=%0d n=%0d expected k=1 n=1", sk, sc); end
        tests++; if (lat !== 12) begin fails++; $display("FAIL basic_latency: got %0d expected 12", lat); end
        tests++; if (q !== 32'h4000_0000 || err !== 1'b0 || rv !== 2'b01)
            begin fails++; $display("FAIL basic_result: got q=%h err=%b rv=%b expected 40000000 0 01", q, err, rv); end
        tests++; if (!st || !ho || !ro) begin fails++; $display("FAIL basic_stable: got %b%b%b expected 111", st, ho, ro); end
    endtask

    task automatic test_round_robin;
        int order[4]; int n, cyc, bad, w, e;
        rst = 1'b1;
        core_en = 1; core_n = 4;
        bus.req_valid = 2'b11; bus.resp_ready = 2'b11;
        bus.req0_dividend = $urandom; bus.req0_divisor = $urandom | 32'h0080_0000;
        bus.req1_dividend = $urandom; bus.req1_divisor = $urandom | 32'h0080_0000;
        @(negedge clk);
        rst = 1'b0;
        mdl_last = 1;
        n = 0; cyc = 0; bad = 0;
        while (n < 4 && cyc < 200) begin
            #1;
            if (bus.req_ready !== 2'b00) begin
                if (bus.busy !== 1'b0 || (bus.req_ready !== 2'b01 && bus.req_ready !== 2'b10)) bad++;
                order[n] = bus.req_ready[1] ? 1 : 0;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.req_valid = 2'b00;
        tests++; if (n !== 4) begin fails++; $display("FAIL rr_count: got %0d expected 4", n); end
        for (int i = 0; i < n; i++) begin
            e = 1 - mdl_last;
            mdl_last = e;
            tests++; if (order[i] !== e) begin fails++; $display("FAIL rr_grant%0d: got %0d expected %0d", i, order[i], e); end
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL rr_ready: got %0d violations expected 0", bad); end
        w = 0;
        while (bus.busy && w < 100) begin @(negedge clk); w++; end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rr_drain: got busy %b expected 0", bus.busy); end
        bus.resp_ready = 2'b00;
    endtask

    task automatic test_bypass;
        logic [1:0] masks[4] = '{2'b10, 2'b01, 2'b11, 2'b01};
        logic [31:0] ops[4][4] = '{
            '{32'h1234_5678, 32'h4000_0000, 32'h3f80_0000, 32'h8000_0000},
            '{32'h0000_0000, 32'h0000_0000, 32'h4000_0000, 32'h4000_0000},
            '{32'h3f80_0000, 32'h3f80_0000, 32'hc000_0000, 32'h0000_0000},
            '{32'h7fc1_2345, 32'h8000_0000, 32'h0, 32'h0}};
        logic [31:0] exp_q[4] = '{32'hff80_0000, 32'h7fc0_0000, 32'hff80_0000, 32'h7fc0_0000};
        int g, lat, sc, sk, eg; logic [31:0] q; logic err; logic [1:0] rv; bit st, ho, ro;
        for (int i = 0; i < 4; i++) begin
            eg = exp_grant(masks[i]);
            do_txn(masks[i], ops[i][0], ops[i][1], ops[i][2], ops[i][3], i, g, lat, q, err, rv, sc, sk, st, ho, ro);
            mdl_last = eg;
            tests++; if (g !== eg || lat !== 1 || sc !== 0)
                begin fails++; $display("FAIL bypass%0d_timing: got g=%0d lat=%0d starts=%0d expected g=%0d lat=1 starts=0", i, g, lat, sc, eg); end
            tests++; if (q !== exp_q[i] || err !== 1'b0 || rv !== (eg ? 2'b10 : 2'b01) || !ho)
                begin fails++; $display("FAIL bypass%0d_result: got q=%h err=%b rv=%b hold=%b expected q=%h err=0", i, q, err, rv, ho, exp_q[i]); end
        end
    endtask

    task automatic test_timeout;
        int g, lat, sc, sk; logic [31:0] q; logic err; logic [1:0] rv; bit st, ho, ro;
        int ns[3] = '{0, TO, TO - 1};
        logic [31:0] a, b;
        for (int i = 0; i < 3; i++) begin
            core_en = (ns[i] != 0);
            core_n = ns[i];
            a = $urandom; b = $urandom | 32'h0100_0000;
            do_txn(2'b01, a, b, 32'h0, 32'h0, 0, g, lat, q, err, rv, sc, sk, st, ho, ro);
            mdl_last = 0;
            tests++; if (sc !== 1 || sk !== 1 || !st)
                begin fails++; $display("FAIL timeout%0d_start: got n=%0d k=%0d stable=%b expected 1 1 1", i, sc, sk, st); end
            if (i == 0) begin
                tests++; if (lat !== TO + 2 || q !== 32'h7fc0_0000 || err !== 1'b1)
                    begin fails++; $display("FAIL timeout_abort: got lat=%0d q=%h err=%b expected %0d 7fc00000 1", lat, q, err, TO + 2); end
            end else begin
                tests++; if (lat !== ns[i] + 2 || q !== core_fn(a, b) || err !== 1'b0)
                    begin fails++; $display("FAIL timeout%0d_done: got lat=%0d q=%h err=%b expected %0d %h 0", i, lat, q, err, ns[i] + 2, core_fn(a, b)); end
            end
        end
        core_en = 1;
    endtask

    task automatic test_hold;
        int g, lat, sc, sk; logic [31:0] q; logic err; logic [1:0] rv; bit st, ho, ro;
        logic [31:0] a, b;
        core_n = 3;
        a = $urandom; b = $urandom | 32'h0000_0001;
        do_txn(2'b10, 32'h0, 32'h0, a, b, 5, g, lat, q, err, rv, sc, sk, st, ho, ro);
        mdl_last = 1;
        tests++; if (g !== 1 || lat !== 5 || q !== core_fn(a, b) || rv !== 2'b10)
            begin fails++; $display("FAIL hold_result: got g=%0d lat=%0d q=%h rv=%b expected 1 5 %h 10", g, lat, q, core_fn(a, b), rv); end
        tests++; if (!ho || !ro) begin fails++; $display("FAIL hold_stable: got hold=%b ready=%b expected 1 1", ho, ro); end
    endtask

    task automatic test_reset_mid;
        int g, lat, sc, sk, bad; logic [31:0] q; logic err; logic [1:0] rv; bit st, ho, ro;
        logic [31:0] a, b;
        core_en = 0;
        @(negedge clk);
        bus.req_valid = 2'b01; bus.req0_dividend = 32'h4049_0fdb; bus.req0_divisor = 32'h3fc0_0000;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rmid_busy: got %b expected 1", bus.busy); end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++; if ({bus.req_ready, bus.resp_valid, bus.div_start, bus.busy, bus.resp_err} !== 7'd0)
            begin fails++; $display("FAIL rmid_ctrl: got %b expected 0", {bus.req_ready, bus.resp_valid, bus.div_start, bus.busy, bus.resp_err}); end
        tests++; if ({bus.resp_quotient, bus.div_dividend, bus.div_divisor} !== 96'd0)
            begin fails++; $display("FAIL rmid_data: got %h expected 0", {bus.resp_quotient, bus.div_dividend, bus.div_divisor}); end
        @(negedge clk);
        rst = 1'b0;
        mdl_last = 1;
        repeat (2) @(negedge clk);
        manual_done = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            manual_done = 1'b0;
            if (bus.resp_valid !== 2'b00 || bus.busy !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL rmid_ghost: got %0d bad cycles expected 0", bad); end
        core_en = 1; core_n = 5;
        a = $urandom; b = $urandom | 32'h0000_0100;
        do_txn(2'b11, a, b, $urandom, 32'h3f80_0000, 0, g, lat, q, err, rv, sc, sk, st, ho, ro);
        tests++; if (g !== 0 || lat !== 7 || q !== core_fn(a, b) || err !== 1'b0)
            begin fails++; $display("FAIL rmid_next: got g=%0d lat=%0d q=%h err=%b expected 0 7 %h 0", g, lat, q, err, core_fn(a, b)); end
        mdl_last = 0;
    endtask

    task automatic test_random;
        int g, lat, sc, sk, eg, elat, rd; logic [31:0] q, eq, ea, eb; logic err; logic [1:0] rv, mask; bit st, ho, ro, byp;
        logic [31:0] a0, b0, a1, b1;
        for (int i = 0; i < 20; i++) begin
            mask = 2'($urandom_range(1, 3));
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            if ($urandom_range(0, 3) == 0) b0[30:0] = 31'd0;
            if ($urandom_range(0, 3) == 0) b1[30:0] = 31'd0;
            if ($urandom_range(0, 4) == 0) a0[30:0] = 31'd0;
            if ($urandom_range(0, 4) == 0) a1[30:23] = 8'hff;
            core_n = $urandom_range(1, 8);
            rd = $urandom_range(0, 3);
            eg = exp_grant(mask);
            ea = eg ? a1 : a0;
            eb = eg ? b1 : b0;
            byp = eb[30:0] == 31'd0;
            eq = byp ? bypass_ref(ea, eb) : core_fn(ea, eb);
            elat = byp ? 1 : core_n + 2;
            do_txn(mask, a0, b0, a1, b1, rd, g, lat, q, err, rv, sc, sk, st, ho, ro);
            mdl_last = eg;
            tests++; if (g !== eg || lat !== elat || sc !== (byp ? 0 : 1))
                begin fails++; $display("FAIL rand%0d_flow: got g=%0d lat=%0d starts=%0d expected g=%0d lat=%0d starts=%0d", i, g, lat, sc, eg, elat, byp ? 0 : 1); end
            tests++; if (q !== eq || err !== 1'b0 || rv !== (eg ? 2'b10 : 2'b01))
                begin fails++; $display("FAIL rand%0d_result: got q=%h err=%b rv=%b expected q=%h err=0", i, q, err, rv, eq); end
            tests++; if (!st || !ho || !ro)
                begin fails++; $display("FAIL rand%0d_hold: got stable=%b hold=%b ready=%b expected 1 1 1", i, st, ho, ro); end
        end
    endtask

    initial begin
        bus.req_valid = 2'b00; bus.resp_ready = 2'b00;
        bus.req0_dividend = 32'h0; bus.req0_divisor = 32'h0;
        bus.req1_dividend = 32'h0; bus.req1_divisor = 32'h0;
        test_reset();
        test_basic();
        test_round_robin();
        test_bypass();
        test_timeout();
        test_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/srt_div_arbiter.md
SRT_DIV_ARBITER -- requirements
Module: srt_div_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 64, max cycles in WAIT before abort (range 2..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  2  per-requester request valid, bit i = requester i.
REQ-005 req_ready  out  2  per-requester accept; a request is accepted when req_valid[i] and req_ready[i] are both 1 at a clk edge.
REQ-006 req0_dividend, req0_divisor, req1_dividend, req1_divisor  in  32 each  IEEE-754 FP32 operands.
REQ-007 resp_valid  out  2  response valid toward requester i.
REQ-008 resp_ready  in  2  response accept from requester i.
REQ-009 resp_quotient  out  32  FP32 result, shared by both requesters.
REQ-010 resp_err  out  1  1 = timeout abort; qualified by resp_valid.
REQ-011 busy  out  1  1 whenever state != IDLE.
REQ-012 div_start  out  1  one-cycle start pulse to the shared SRT divider core.
REQ-013 div_dividend, div_divisor  out  32 each  operands to the core.
REQ-014 div_done  in  1  core completion strobe.
REQ-015 div_quotient  in  32  core result, valid while div_done = 1.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: if any req_valid bit is 1, the block SHALL grant one requester, drive req_ready for that requester only (combinationally, IDLE only), capture its operands and grant index.
REQ-018 Round-robin: on a tie, the requester not granted last SHALL win; the last-grant pointer SHALL update on acceptance and reset to 1 (requester 0 wins first).
REQ-019 Bypass: if the captured divisor is +/-0 (bits[30:0] = 0), the next state SHALL be RESP with no div_start; quotient = 7FC00000 if dividend is +/-0 or NaN, else infinity with sign = XOR of operand signs (7F800000/FF800000); resp_err = 0.
REQ-020 Otherwise IDLE -> ISSUE; ISSUE asserts div_start for exactly one cycle, clears the watchdog counter, then -> WAIT.
REQ-021 div_dividend/div_divisor SHALL hold the captured operands, stable from ISSUE until WAIT exits.
REQ-022 WAIT: counter increments each cycle; div_done = 1 -> latch div_quotient, resp_err = 0, -> RESP.
REQ-023 WAIT: counter = TIMEOUT-1 without div_done -> quotient 7FC00000, resp_err = 1, -> RESP; div_done in the same cycle SHALL take priority (normal result).
REQ-024 div_done outside WAIT SHALL be ignored.
REQ-025 RESP: resp_valid[grant] = 1, other bit 0; quotient and err held until resp_ready[grant] = 1 at an edge, then -> IDLE; resp_ready of the non-granted requester is ignored.
REQ-026 Latency: acceptance edge at cycle T, div_start high in T+1, div_done in cycle T+1+N (N >= 1) -> resp_valid from T+2+N; bypass -> resp_valid from T+1; timeout -> resp_valid from T+2+TIMEOUT.
REQ-027 At most one transaction SHALL be outstanding; req_ready = 00 in every state but IDLE.
REQ-028 A new request SHALL be accepted no earlier than the cycle after the response handshake (IDLE re-entered).

Reset
REQ-029 On rst = 1, immediately and asynchronously: state IDLE; req_ready, resp_valid, div_start, busy, resp_err = 0; resp_quotient, div_dividend, div_divisor = 0; counter = 0; last-grant = 1.
REQ-030 Reset mid-transaction SHALL abandon it silently: no response is produced, and a later div_done is ignored.

Verification
REQ-031 req0 = 40800000 / 40000000, core model done after N = 10 -> div_start at T+1, resp_valid[0] at T+12, quotient 40000000, err 0.
REQ-032 Both req_valid held 1 from reset, core N = 4 -> grant order 0,1,0,1; req_ready one-hot, never asserted outside IDLE.
REQ-033 req1 = 3F800000 / 80000000 -> resp_valid[1] at T+1, quotient FF800000, div_start never pulses; 00000000 / 00000000 -> 7FC00000.
REQ-034 Core never asserts div_done, TIMEOUT = 64 -> resp_valid at T+66, quotient 7FC00000, err 1; repeat with div_done in the final WAIT cycle -> normal result, err 0.
REQ-035 resp_ready held 0 for 5 cycles in RESP -> resp_valid, quotient, err stable; req_ready = 00; busy = 1.
REQ-036 rst pulsed during WAIT -> all outputs 0 the same cycle; a div_done 3 cycles later produces no resp_valid; the next request is served normally.
